// File: rtl/med_filt_pkg.sv
// Shared constants, sequencer state encoding and window packing order
// for the 7-tap median filter.
package med_filt_pkg;

    localparam int DW   = 8;
    localparam int TAPS = 7;
    localparam int HALF = (TAPS - 1) / 2;

    typedef enum logic [3:0] {
        IDLE,
        PRIME,
        LAUNCH,
        WAIT_SORT,
        WRITE,
        WAIT_STEP,
        FETCH,
        FETCH_WAIT,
        TAIL,
        DONE
    } state_t;

    // Oldest window entry sits in the MSBs of the packed sorter input.
    function automatic int unsigned win_lsb(input int unsigned idx, input int unsigned taps,
                                            input int unsigned dw);
        return (taps - 1 - idx) * dw;
    endfunction

endpackage

// File: rtl/med_win_sreg.sv
// Sliding sample window: new samples enter at the newest slot, the oldest drops out.
module med_win_sreg #(
    parameter int DW   = med_filt_pkg::DW,
    parameter int TAPS = med_filt_pkg::TAPS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_en,
    input  logic [DW-1:0]        din,
    output logic [TAPS*DW-1:0]   win_flat
);
    import med_filt_pkg::*;

    logic [DW-1:0] win [TAPS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < TAPS; i++) win[i] <= '0;
        end else if (shift_en) begin
            for (int unsigned i = 0; i < TAPS - 1; i++) win[i] <= win[i + 1];
            win[TAPS-1] <= din;
        end
    end

    always_comb begin
        win_flat = '0;
        for (int unsigned i = 0; i < TAPS; i++) win_flat[win_lsb(i, TAPS, DW) +: DW] = win[i];
    end

endmodule

// File: rtl/med_filt_seq.sv
// Median filter sequencer: primes a sliding window from the sample RAM, runs the
// sorter once per window and writes medians (edges passed through) to the result RAM.
module med_filt_seq #(
    parameter int DW        = med_filt_pkg::DW,
    parameter int AW        = 7,
    parameter int N_SAMPLES = 100,
    parameter int TAPS      = med_filt_pkg::TAPS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 step_mode,
    input  logic                 step,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    input  logic [DW-1:0]        rd_data,
    output logic [TAPS*DW-1:0]   sort_in,
    output logic                 sort_start,
    input  logic                 sort_done,
    input  logic [DW-1:0]        sort_med,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [DW-1:0]        wr_data,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        cur_idx
);
    import med_filt_pkg::*;

    localparam int            SIDE   = (TAPS - 1) / 2;
    localparam logic [AW-1:0] TAPS_A = AW'(TAPS);
    localparam logic [AW-1:0] LAST_A = AW'(TAPS - 1);
    localparam logic [AW-1:0] SIDE_A = AW'(SIDE);
    localparam logic [AW-1:0] TAIL_A = AW'(N_SAMPLES - SIDE);
    localparam logic [AW:0]   N_END  = (AW+1)'(N_SAMPLES);

    state_t        state;
    logic [AW-1:0] base;
    logic [AW-1:0] rc;
    logic [AW-1:0] tk;
    logic [AW-1:0] vld_addr;
    logic          vld;
    logic          wr_thru;
    logic [DW-1:0] wr_q;
    logic [DW-1:0] tail_samp;

    // vld marks the cycle a read issued last cycle has its data on rd_data.
    med_win_sreg #(.DW(DW), .TAPS(TAPS)) u_win (
        .clk      (clk),
        .rst      (rst),
        .shift_en (vld),
        .din      (rd_data),
        .win_flat (sort_in)
    );

    // Leading edge samples are written in the same cycle the RAM returns them.
    assign wr_data = (wr_en && wr_thru) ? rd_data : wr_q;

    always_comb begin
        tail_samp = '0;
        for (int unsigned k = 0; k < SIDE; k++)
            if (tk == AW'(k)) tail_samp = sort_in[win_lsb(TAPS - SIDE + k, TAPS, DW) +: DW];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            base       <= '0;
            rc         <= '0;
            tk         <= '0;
            vld        <= 1'b0;
            vld_addr   <= '0;
            wr_thru    <= 1'b0;
            wr_q       <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            sort_start <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cur_idx    <= '0;
        end else begin
            rd_en      <= 1'b0;
            sort_start <= 1'b0;
            wr_en      <= 1'b0;
            vld        <= rd_en;
            vld_addr   <= rd_addr;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= PRIME;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        base    <= '0;
                        tk      <= '0;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        rc      <= AW'(1);
                    end
                end
                PRIME: begin
                    if (rc < TAPS_A) begin
                        rd_en   <= 1'b1;
                        rd_addr <= rc;
                        rc      <= rc + 1'b1;
                    end
                    if (rd_en && rd_addr < SIDE_A) begin
                        wr_en   <= 1'b1;
                        wr_thru <= 1'b1;
                        wr_addr <= rd_addr;
                        cur_idx <= rd_addr;
                    end
                    if (vld && vld_addr == LAST_A) state <= LAUNCH;
                end
                LAUNCH: begin
                    sort_start <= 1'b1;
                    state      <= WAIT_SORT;
                end
                WAIT_SORT: begin
                    if (sort_done) begin
                        state   <= WRITE;
                        wr_en   <= 1'b1;
                        wr_thru <= 1'b0;
                        wr_addr <= base + SIDE_A;
                        cur_idx <= base + SIDE_A;
                        wr_q    <= sort_med;
                    end
                end
                WRITE: begin
                    if ({1'b0, base} + {1'b0, TAPS_A} == N_END) begin
                        state   <= TAIL;
                        wr_en   <= 1'b1;
                        wr_thru <= 1'b0;
                        wr_addr <= TAIL_A;
                        cur_idx <= TAIL_A;
                        wr_q    <= tail_samp;
                        tk      <= tk + 1'b1;
                    end else if (step_mode) begin
                        state <= WAIT_STEP;
                    end else begin
                        state   <= FETCH;
                        rd_en   <= 1'b1;
                        rd_addr <= base + TAPS_A;
                    end
                end
                WAIT_STEP: begin
                    if (step) begin
                        state   <= FETCH;
                        rd_en   <= 1'b1;
                        rd_addr <= base + TAPS_A;
                    end
                end
                FETCH: state <= FETCH_WAIT;
                FETCH_WAIT: begin
                    base  <= base + 1'b1;
                    state <= LAUNCH;
                end
                TAIL: begin
                    if (tk < SIDE_A) begin
                        wr_en   <= 1'b1;
                        wr_addr <= TAIL_A + tk;
                        cur_idx <= TAIL_A + tk;
                        wr_q    <= tail_samp;
                        tk      <= tk + 1'b1;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_med_filt_seq.sv
// Directed bench for med_filt_seq with a RAM model and a fixed-latency sorter model.
module tb_med_filt_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic        rd_en;
    logic [6:0]  rd_addr;
    logic [7:0]  rd_data = '0;
    logic [55:0] sort_in;
    logic        sort_start;
    logic        sort_done;
    logic [7:0]  sort_med;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic [6:0]  cur_idx;

    logic [7:0]  mem [128];
    logic [7:0]  exp_med [100];
    logic [7:0]  saved [100];
    logic [6:0]  log_addr [$];
    logic [7:0]  log_data [$];
    int          n_launch = 0;
    int          n_rd = 0;
    int          checks = 0;
    int          passed = 0;

    logic        sd_q = 1'b0;
    logic        sd_inj = 1'b0;
    logic [7:0]  med_q = '0;
    int          cnt = 0;
    int          lat = 3;

    med_filt_seq #(.DW(8), .AW(7), .N_SAMPLES(100), .TAPS(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .step_mode  (step_mode),
        .step       (step),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .sort_in    (sort_in),
        .sort_start (sort_start),
        .sort_done  (sort_done),
        .sort_med   (sort_med),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .cur_idx    (cur_idx)
    );

    always #5 clk = ~clk;

    assign sort_done = sd_q | sd_inj;
    assign sort_med  = med_q;

    function automatic logic [7:0] median7(input logic [55:0] w);
        logic [7:0] s [7];
        logic [7:0] t;
        for (int i = 0; i < 7; i++) s[i] = w[i*8 +: 8];
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6 - i; j++)
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        return s[3];
    endfunction

    function automatic logic [55:0] pack_win(input int b);
        logic [55:0] w;
        for (int j = 0; j < 7; j++) w[(6-j)*8 +: 8] = mem[b + j];
        return w;
    endfunction

    function automatic int count_bad();
        int b = 0;
        if (log_addr.size() != 100) b++;
        for (int i = 0; i < log_addr.size() && i < 100; i++)
            if (log_addr[i] !== 7'(i) || log_data[i] !== exp_med[i]) b++;
        return b;
    endfunction

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sd_q <= 1'b0;
            cnt  <= 0;
        end else begin
            sd_q <= 1'b0;
            if (sort_start) begin
                med_q <= median7(sort_in);
                if (lat <= 1) sd_q <= 1'b1;
                else cnt <= lat - 1;
            end else if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) sd_q <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (wr_en) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
        if (sort_start) n_launch++;
        if (rd_en) n_rd++;
    end

    task automatic clear_logs();
        log_addr.delete();
        log_data.delete();
        n_launch = 0;
        n_rd = 0;
    endtask

    task automatic compute_exp();
        for (int i = 0; i < 100; i++)
            exp_med[i] = (i < 3 || i > 96) ? mem[i] : median7(pack_win(i - 3));
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_step();
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (log_addr.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, rd_en, wr_en, sort_start, cur_idx, wr_addr, rd_addr, wr_data} !== '0)
            $display("FAIL reset_ctrl: got %h want 0",
                     {busy, done, rd_en, wr_en, sort_start, cur_idx, wr_addr, rd_addr, wr_data});
        else passed++;
        checks++;
        if (sort_in !== 56'h0) $display("FAIL reset_win: got %h want 0", sort_in);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_prime();
        bit ok;
        logic [7:0] hv [8];
        logic [7:0] ev [5];
        hv = '{8'h7D, 8'hE0, 8'h5B, 8'h73, 8'hF6, 8'h0B, 8'hF9, 8'h31};
        ev = '{8'h7D, 8'hE0, 8'h5B, 8'h7D, 8'h73};
        for (int i = 0; i < 128; i++) mem[i] = (i < 8) ? hv[i] : 8'($urandom);
        compute_exp();
        step_mode = 1'b0;
        lat = 3;
        clear_logs();
        pulse_start();
        checks++;
        if ({busy, done} !== 2'b10) $display("FAIL start_busy: got %b want 10", {busy, done});
        else passed++;
        wait_writes(5, 200, ok);
        checks++;
        if (!ok) $display("FAIL prime_timeout: got %0d writes want 5", log_addr.size());
        else passed++;
        for (int i = 0; i < 5 && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== 7'(i) || log_data[i] !== ev[i])
                $display("FAIL prime_w%0d: got %h@%0d want %h@%0d", i, log_data[i], log_addr[i], ev[i], i);
            else passed++;
        end
        wait_done(3000, ok);
        checks++;
        if (!ok) $display("FAIL prime_done: got done=%b want 1", done);
        else passed++;
    endtask

    task automatic test_full_pass();
        bit ok;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        compute_exp();
        clear_logs();
        pulse_start();
        wait_done(3000, ok);
        checks++;
        if (!ok) $display("FAIL full_timeout: got done=%b want 1", done);
        else passed++;
        checks++;
        if (log_addr.size() != 100) $display("FAIL full_count: got %0d want 100", log_addr.size());
        else passed++;
        for (int i = 0; i < 100 && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== 7'(i) || log_data[i] !== exp_med[i])
                $display("FAIL full_w%0d: got %h@%0d want %h@%0d", i, log_data[i], log_addr[i], exp_med[i], i);
            else passed++;
        end
        checks++;
        if (n_launch != 94) $display("FAIL full_launches: got %0d want 94", n_launch);
        else passed++;
        checks++;
        if ({busy, done, cur_idx} !== {2'b01, 7'd99})
            $display("FAIL full_end: got %b/%b/%0d want 0/1/99", busy, done, cur_idx);
        else passed++;
    endtask

    task automatic test_step_mode();
        bit ok;
        step_mode = 1'b1;
        clear_logs();
        pulse_start();
        wait_writes(4, 200, ok);
        checks++;
        if (!ok || log_data[3] !== exp_med[3] || log_addr[3] !== 7'd3)
            $display("FAIL step_first: got %0d writes want 4 ending %h@3", log_addr.size(), exp_med[3]);
        else passed++;
        n_rd = 0;
        n_launch = 0;
        repeat (20) @(negedge clk);
        checks++;
        if ({log_addr.size(), n_rd, n_launch} !== {32'd4, 32'd0, 32'd0})
            $display("FAIL step_hold: got w=%0d rd=%0d launch=%0d want 4/0/0", log_addr.size(), n_rd, n_launch);
        else passed++;
        @(negedge clk) sd_inj = 1'b1;
        @(negedge clk) sd_inj = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (log_addr.size() != 4) $display("FAIL step_spurious: got %0d writes want 4", log_addr.size());
        else passed++;
        for (int s = 4; s < 6; s++) begin
            pulse_step();
            repeat (20) @(negedge clk);
            checks++;
            if (log_addr.size() != s + 1 || log_addr[s] !== 7'(s) || log_data[s] !== exp_med[s])
                $display("FAIL step_pulse%0d: got %0d writes want %0d ending %h", s, log_addr.size(), s + 1, exp_med[s]);
            else passed++;
        end
        step_mode = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (log_addr.size() != 6) $display("FAIL step_clear_hold: got %0d writes want 6", log_addr.size());
        else passed++;
        pulse_step();
        wait_done(3000, ok);
        checks++;
        if (!ok || count_bad() != 0) $display("FAIL step_finish: got %0d bad want 0", count_bad());
        else passed++;
    endtask

    task automatic test_stall();
        bit ok;
        logic [55:0] snap;
        int cyc;
        int changes;
        lat = 50;
        clear_logs();
        pulse_start();
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (n_launch >= 1) begin
                ok = 1'b1;
                break;
            end
        end
        snap = sort_in;
        lat = 3;
        checks++;
        if (!ok || snap !== pack_win(0)) $display("FAIL stall_window: got %h want %h", snap, pack_win(0));
        else passed++;
        cyc = 0;
        changes = 0;
        while (log_addr.size() < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (sort_in !== snap) changes++;
        end
        checks++;
        if (changes != 0) $display("FAIL stall_stable: got %0d changes want 0", changes);
        else passed++;
        checks++;
        if (n_launch != 1 || cyc < 50 || log_addr.size() != 4)
            $display("FAIL stall_single: got launch=%0d cyc=%0d w=%0d want 1/>=50/4", n_launch, cyc, log_addr.size());
        else passed++;
        wait_done(3000, ok);
        checks++;
        if (!ok || count_bad() != 0) $display("FAIL stall_finish: got %0d bad want 0", count_bad());
        else passed++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n0;
        clear_logs();
        pulse_start();
        wait_writes(23, 500, ok);
        n0 = n_launch;
        for (int c = 0; c < 20 && n_launch <= n0; c++) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, rd_en, wr_en, sort_start, cur_idx, wr_addr, rd_addr, wr_data, sort_in} !== '0)
            $display("FAIL rst_mid: got busy=%b cur=%0d win=%h want all 0", busy, cur_idx, sort_in);
        else passed++;
        checks++;
        if (!ok || n_launch != n0 + 1) $display("FAIL rst_mid_point: got launch=%0d want %0d", n_launch, n0 + 1);
        else passed++;
        @(negedge clk) rst = 1'b0;
        clear_logs();
        pulse_start();
        ok = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (rd_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok || rd_addr !== 7'd0) $display("FAIL rst_reprime: got rd_en=%b addr=%0d want 1/0", rd_en, rd_addr);
        else passed++;
        wait_done(3000, ok);
        checks++;
        if (!ok || count_bad() != 0 || n_launch != 94)
            $display("FAIL rst_rerun: got bad=%0d launch=%0d want 0/94", count_bad(), n_launch);
        else passed++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_logs();
        pulse_start();
        wait_writes(10, 300, ok);
        pulse_start();
        wait_writes(50, 600, ok);
        pulse_start();
        wait_done(3000, ok);
        checks++;
        if (!ok || count_bad() != 0 || n_launch != 94)
            $display("FAIL busy_start: got bad=%0d launch=%0d want 0/94", count_bad(), n_launch);
        else passed++;
        for (int i = 0; i < 100; i++) saved[i] = (i < log_data.size()) ? log_data[i] : 8'h00;
        clear_logs();
        pulse_start();
        checks++;
        if ({busy, done} !== 2'b10) $display("FAIL restart_flags: got %b want 10", {busy, done});
        else passed++;
        wait_done(3000, ok);
        ok = ok && (log_data.size() == 100);
        for (int i = 0; i < 100 && i < log_data.size(); i++) if (log_data[i] !== saved[i]) ok = 1'b0;
        checks++;
        if (!ok) $display("FAIL restart_same: got %0d writes, second pass differs want identical", log_data.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_prime();
        test_full_pass();
        test_step_mode();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/med_filt_seq.md
Name: med_filt_seq

Overview:
Sequencer for the 7-tap 1-D median datapath. It walks a sample RAM and maintains a sliding 7-sample window. For each window it launches the sorter with a start/done handshake and writes the median into a result RAM. Edge samples pass through unchanged. It supports free-run mode and single-step mode, where the step input is driven by the debounced push-button pulse.

Parameters:
DW, 8, sample width in bits
AW, 7, sample/result RAM address width
N_SAMPLES, 100, number of samples processed; must be at least TAPS and at most 2**AW
TAPS, 7, window length; odd; HALF = (TAPS-1)/2 = 3

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
start  in  1  1-cycle pulse; begins a pass; ignored while busy=1
step_mode  in  1  1: pause after each median write; 0: free-run
step  in  1  1-cycle pulse; releases one pause; ignored outside WAIT_STEP
rd_en  out  1  sample RAM read strobe
rd_addr  out  AW  sample RAM address; data returns on rd_data one cycle after rd_en
rd_data  in  DW  sample RAM read data
sort_in  out  TAPS*DW  window; win[0] (oldest) in the MSBs, win[6] (newest) in the LSBs
sort_start  out  1  1-cycle launch pulse to the sorter
sort_done  in  1  1-cycle pulse; sort_med is valid in the same cycle
sort_med  in  DW  median from the sorter
wr_en  out  1  result RAM write strobe
wr_addr  out  AW  result RAM address
wr_data  out  DW  result RAM data
busy  out  1  high from the start acceptance cycle through the last write
done  out  1  high after a completed pass until the next accepted start or rst
cur_idx  out  AW  address of the last result written (drives the display)

Behaviour:
- Reset values: all outputs 0; window registers 0; state IDLE; base 0.
- States: IDLE, PRIME, LAUNCH, WAIT_SORT, WRITE, WAIT_STEP, FETCH, FETCH_WAIT, TAIL, DONE.
- IDLE/DONE:
  - On start, go to PRIME: busy=1, done=0, rd counter=0, base=0.
- PRIME:
  - Issue rd_en on addresses 0..TAPS-1, one per cycle, back-to-back.
  - Each returned sample shifts into win[6]; the older entries shift toward win[0].
  - Samples at addresses 0..HALF-1 are also written through in the cycle they return: wr_addr equals the sample address, wr_data equals rd_data.
  - The cycle after the TAPS-th sample returns, go to LAUNCH.
- LAUNCH:
  - sort_start=1 for exactly one cycle, then go to WAIT_SORT.
  - sort_in is held stable from LAUNCH until sort_done.
- WAIT_SORT:
  - Waits indefinitely for sort_done.
  - On sort_done, register sort_med and go to WRITE.
  - A sort_done seen in any other state is ignored.
- WRITE:
  - wr_en=1, wr_addr=base+HALF, wr_data=registered median; cur_idx updates to the same address.
  - Next state:
    - if base+TAPS==N_SAMPLES: TAIL
    - else if step_mode=1: WAIT_STEP
    - else: FETCH.
- WAIT_STEP:
  - On step, go to FETCH.
  - step_mode is sampled only in WRITE. Clearing step_mode while in WAIT_STEP still requires one step pulse.
- FETCH:
  - rd_en=1, rd_addr=base+TAPS, then go to FETCH_WAIT.
- FETCH_WAIT:
  - Shift rd_data into the window; base=base+1; go to LAUNCH.
- TAIL:
  - Three consecutive wr_en cycles write win[4], win[5], win[6] to addresses N_SAMPLES-3, N_SAMPLES-2, N_SAMPLES-1.
  - cur_idx tracks each write.
  - After the third write: busy=0, done=1, go to DONE.
- Totals per pass:
  - Exactly N_SAMPLES writes, each address written once, in ascending order.
  - Exactly N_SAMPLES-TAPS+1 sort launches.
  - Never more than one sort outstanding.
- Free-run timing with sorter latency L (sort_done L cycles after sort_start): 5+L cycles per median after priming.
- Address arithmetic is unsigned AW-bit and never wraps, given the N_SAMPLES constraint.
- rst mid-pass: immediate abort to IDLE with all outputs 0. A partial result RAM is left as is.
- start while busy: ignored. start in DONE: new pass.

Decomposition:
- Package med_filt_pkg holds:
  - DW, TAPS, HALF
  - the state enum
  - a helper function for the window pack order.
- Sub-module med_win_sreg: a TAPS x DW shift register with shift enable, asynchronous reset, and packed output.

Test Plan:
- Prime and first medians: RAM[0..7]=7D,E0,5B,73,F6,0B,F9,31, step_mode=0, sorter model L=3, start -> writes addr0=7D, addr1=E0, addr2=5B, addr3=7D, addr4=73.
- Full pass with 100 random samples, free-run -> 100 writes in ascending order; every interior result equals the reference median; edge results equal the input samples; done=1; exactly 94 sort_start pulses.
- Step mode: step_mode=1, no step pulse -> FSM holds in WAIT_STEP after the addr3 write with no rd_en or sort_start. Each step pulse -> exactly one more write.
- Sorter stall: sort_done delayed 50 cycles -> sort_in stable throughout and no extra sort_start. A spurious sort_done in WAIT_STEP -> no write.
- Reset mid-pass: rst asserted in WAIT_SORT at base=20 -> all outputs 0 asynchronously. A new start reprimes from addr 0.
- start pulse while busy -> no effect on the write sequence. start in DONE -> second pass yields identical results.
